// File: rtl/stfq_pkg.sv
// Shared types, defaults and saturating arithmetic for the STFQ ranker.
package stfq_pkg;

    typedef logic [31:0] rank_t;
    typedef logic [15:0] len_t;

    localparam int DEFAULT_SHIFT_W = 4;

    // 32-bit add that clamps at all-ones instead of wrapping.
    function automatic rank_t sat_add(input rank_t a, input rank_t b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/stfq_ranker_onehot_chk.sv
// One-hot checker: flags a vector with exactly one bit set and encodes its index.
module onehot_chk #(
    parameter int FLOWS = 10,
    parameter int IDX_W = (FLOWS > 1) ? $clog2(FLOWS) : 1
) (
    input  logic [FLOWS-1:0] vec,
    output logic             is_onehot,
    output logic [IDX_W-1:0] idx
);

    // Power-of-two test for validity, priority-free encode of the set bit.
    always_comb begin
        is_onehot = (vec != '0) && ((vec & (vec - FLOWS'(1))) == '0);
        idx       = '0;
        for (int i = 0; i < FLOWS; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/stfq_ranker.sv
// Start-time fair queueing ranker: stamps each packet with its virtual start
// time and tracks per-flow finish times. Optional drop counter enabled by
// defining STFQ_DROP_CNT_EN.
module stfq_ranker
    import stfq_pkg::*;
#(
    parameter int FLOWS   = 10,
    parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLOWS-1:0]   in_flow,
    input  logic [15:0]        in_len,
    input  logic [31:0]        in_value,
    output logic               push,
    output logic [31:0]        push_rank,
    output logic [31:0]        push_value,
    output logic [FLOWS-1:0]   push_flow,
    input  logic               deq_valid,
    input  logic [31:0]        deq_rank,
    input  logic               cfg_we,
    input  logic [FLOWS-1:0]   cfg_flow,
    input  logic [SHIFT_W-1:0] cfg_shift
`ifdef STFQ_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int IDX_W = (FLOWS > 1) ? $clog2(FLOWS) : 1;

    logic               in_oh;
    logic [IDX_W-1:0]   in_idx;
    logic               cfg_oh;
    logic [IDX_W-1:0]   cfg_idx;

    rank_t              finish_q [FLOWS];
    rank_t              finish_d [FLOWS];
    logic [SHIFT_W-1:0] shift_q  [FLOWS];
    logic [SHIFT_W-1:0] shift_d  [FLOWS];
    rank_t              vtime_q, vtime_d;

    logic               push_q, push_d;
    rank_t              push_rank_q, push_rank_d;
    logic [31:0]        push_value_q, push_value_d;
    logic [FLOWS-1:0]   push_flow_q, push_flow_d;

    logic               accept;
    rank_t              cur_finish;
    rank_t              start;
    rank_t              scaled_len;

    onehot_chk #(.FLOWS(FLOWS), .IDX_W(IDX_W)) u_in_chk (
        .vec       (in_flow),
        .is_onehot (in_oh),
        .idx       (in_idx)
    );

    onehot_chk #(.FLOWS(FLOWS), .IDX_W(IDX_W)) u_cfg_chk (
        .vec       (cfg_flow),
        .is_onehot (cfg_oh),
        .idx       (cfg_idx)
    );

    // The block never backpressures; it only refuses packets while in reset.
    assign in_ready = ~rst;

    // Rank computation and next-state for per-flow state, vtime and push fields.
    // Everything reads the registered (old) vtime/shift, so same-cycle deq or
    // cfg writes take effect only for later packets.
    always_comb begin
        accept     = in_valid && in_ready;
        cur_finish = finish_q[in_idx];
        start      = (vtime_q > cur_finish) ? vtime_q : cur_finish;
        scaled_len = rank_t'(in_len >> shift_q[in_idx]);

        finish_d = finish_q;
        shift_d  = shift_q;
        if (accept && in_oh) finish_d[in_idx] = sat_add(start, scaled_len);
        if (cfg_we && cfg_oh) shift_d[cfg_idx] = cfg_shift;

        vtime_d = vtime_q;
        if (deq_valid && (deq_rank > vtime_q)) vtime_d = deq_rank;

        push_d       = accept && in_oh;
        push_rank_d  = push_rank_q;
        push_value_d = push_value_q;
        push_flow_d  = push_flow_q;
        if (push_d) begin
            push_rank_d  = start;
            push_value_d = in_value;
            push_flow_d  = in_flow;
        end
    end

    // State registers; async reset clears everything, killing any pending push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                finish_q[f] <= '0;
                shift_q[f]  <= '0;
            end
            vtime_q      <= '0;
            push_q       <= 1'b0;
            push_rank_q  <= '0;
            push_value_q <= '0;
            push_flow_q  <= '0;
        end else begin
            finish_q     <= finish_d;
            shift_q      <= shift_d;
            vtime_q      <= vtime_d;
            push_q       <= push_d;
            push_rank_q  <= push_rank_d;
            push_value_q <= push_value_d;
            push_flow_q  <= push_flow_d;
        end
    end

    assign push       = push_q;
    assign push_rank  = push_rank_q;
    assign push_value = push_value_q;
    assign push_flow  = push_flow_q;

`ifdef STFQ_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count accepted packets whose flow vector is not one-hot, saturating.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !in_oh && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/stfq_ranker.md
STFQ_RANKER -- requirements
Module: stfq_ranker

Interface
REQ-001 SHALL have parameter FLOWS, default 10, meaning number of flows and width of one-hot flow vectors.
REQ-002 SHALL have parameter SHIFT_W, default 4, meaning width of the per-flow weight shift.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  packet offered.
REQ-006 SHALL have port in_ready  output  1  packet accepted when in_valid && in_ready.
REQ-007 SHALL have port in_flow  input  FLOWS  one-hot flow of the offered packet.
REQ-008 SHALL have port in_len  input  16  packet length, in bytes.
REQ-009 SHALL have port in_value  input  32  opaque payload, passed through.
REQ-010 SHALL have port push  output  1  one-cycle pulse, rank-store enqueue.
REQ-011 SHALL have ports push_rank (32), push_value (32) and push_flow (FLOWS), all outputs, carrying the enqueue fields.
REQ-012 SHALL have ports deq_valid (input, 1) and deq_rank (input, 32): dequeue notification from the rank store.
REQ-013 SHALL have ports cfg_we (input, 1), cfg_flow (input, FLOWS, one-hot) and cfg_shift (input, SHIFT_W): weight write.

Function
REQ-014 SHALL hold per-flow state finish[f] (32b) and shift[f] (SHIFT_W), plus a global vtime (32b).
REQ-015 in_ready SHALL be 1 in every cycle that rst is deasserted, and 0 while rst is asserted.
REQ-016 On accept with one-hot flow f: start = max(vtime, finish[f]); finish[f] <= sat32(start + (in_len >> shift[f])).
REQ-017 push SHALL assert exactly one cycle after the accept, with push_rank = start, push_value = in_value and push_flow = in_flow; latency is fixed at 1.
REQ-018 push SHALL be 0 in every cycle not following a valid accept; push is never stalled because the store has no backpressure.
REQ-019 Back-to-back accepts to the same flow SHALL see the finish[f] written by the previous accept (no hazard bubble).
REQ-020 An in_flow that is zero or multi-hot SHALL be dropped: no push and no state change.
REQ-021 On deq_valid: vtime <= max(vtime, deq_rank); vtime is non-decreasing.
REQ-022 When deq_valid and an accept occur in the same cycle, start SHALL use the pre-update vtime.
REQ-023 On cfg_we: shift[f] <= cfg_shift for the one-hot cfg_flow; a zero or multi-hot cfg_flow is ignored.
REQ-024 When cfg_we and an accept hit the same flow in the same cycle, the accept SHALL use the old shift.
REQ-025 All 32b addition SHALL saturate at 0xFFFFFFFF and never wrap.

Reset
REQ-026 On rst assertion (asynchronous), the block SHALL set push=0, push_rank=0, push_value=0, push_flow=0, vtime=0, all finish=0 and all shift=0.
REQ-027 A packet accepted in the cycle before rst asserts SHALL NOT produce a push.
REQ-028 Operation SHALL resume on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro STFQ_DROP_CNT_EN defined: the block SHALL add output drop_cnt (16b), reset 0, incrementing by 1 on each REQ-020 drop and saturating at 0xFFFF.
REQ-030 Macro STFQ_DROP_CNT_EN undefined: the block SHALL have no drop_cnt port and no counter logic; drop behaviour is otherwise identical.

Structure
REQ-031 Package stfq_pkg SHALL hold rank_t (32b), len_t (16b), the default SHIFT_W and the saturating-add function.
REQ-032 One sub-module, onehot_chk, SHALL be parameterised by FLOWS and output is_onehot and the flow index; it SHALL be used for both in_flow and cfg_flow.
REQ-033 Per-flow state SHALL be arrays in stfq_ranker and SHALL NOT be split into per-flow instances.

Verification
REQ-034 After reset, accept flow 0x001 with len=100 -> next cycle push=1, push_rank=0, push_flow=0x001; finish[0]=100.
REQ-035 Two back-to-back accepts to flow 0 with len 100 and 50 -> push_rank 0, then 100; finish[0]=150.
REQ-036 deq_valid with deq_rank=500, then accept flow 1 (finish 0) with len 10 -> push_rank=500, finish[1]=510; a later deq_rank=200 leaves vtime=500.
REQ-037 cfg flow 2 shift=2, then accept len=64 -> finish[2]=16; cfg and accept to flow 2 in the same cycle -> old shift used.
REQ-038 Accept with in_flow=0x003, then with 0x000 -> no push; with STFQ_DROP_CNT_EN, drop_cnt=2.
REQ-039 Preload finish[0]=0xFFFFFFF0 and accept len=0x100 -> finish[0]=0xFFFFFFFF; assert rst mid-stream -> push=0 immediately and all state 0.
